uart_stream_tx: RTL

//  8N1 UART transmitter; the transmit end of the logic-analyzer UART stream path.

---
 rtl/logic_uart_pkg.sv | 35 +++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_stream_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/logic_uart_pkg.sv
// Shared definitions for the logic-analyzer UART stream path (transmitter and
// receiver). Both sides derive the bit period from the same frequency table,
// so a transmitter/receiver pair at the same select code loops back cleanly.
package logic_uart_pkg;

  // Sample frequency in Hz for each select code 0x0..0xF.
  localparam int unsigned FREQ_HZ [16] = '{
    32'd50,      32'd250,     32'd500,      32'd2500,
    32'd5000,    32'd25000,   32'd50000,    32'd100000,
    32'd250000,  32'd500000,  32'd1000000,  32'd2500000,
    32'd5000000, 32'd6250000, 32'd12500000, 32'd25000000
  };

  localparam int unsigned BAUD_DEFAULT    = 115200;
  localparam int unsigned MIN_BIT_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Cycles per bit for a select code: truncated FREQ/baud, clamped below.
  function automatic logic [15:0] bit_period(input logic [3:0] sel,
                                             input int unsigned baud,
                                             input int unsigned min_bit);
    int unsigned q;
    q = FREQ_HZ[sel] / baud;
    if (q < min_bit) q = min_bit;
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit timer for the UART stream transmitter. The period is loaded when a
// frame is accepted and held for the whole frame; the counter is held at
// zero while not running and emits a tick in the cycle where it reaches
// period-1, then wraps to zero.
module uart_bit_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        load,
  input  logic [15:0] period,
  input  logic        run,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] period_q;

  assign tick = run && (cnt == (period_q - 16'd1));

  // Cycle counter within the current bit; cleared on load, idle or wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= 16'd0;
    end else if (load || !run || tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Frame period register; only meaningful while running, so no reset.
  always_ff @(posedge i_clk) begin
    if (load) period_q <= period;
  end

endmodule

// File: rtl/uart_stream_tx.sv
// UART stream transmitter (8N1, LSB first) for the logic-analyzer stream
// path. Bytes arrive on a valid/ready stream; ready is high only while idle,
// so there is no buffering. The bit period is selected by the same code
// table as the stream receiver and is frozen per frame at accept time.
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity bit
// between the data bits and the stop bit (11 bit periods per frame).
module uart_stream_tx
  import logic_uart_pkg::*;
#(
  parameter int unsigned BAUD    = BAUD_DEFAULT,
  parameter int unsigned MIN_BIT = MIN_BIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_logic_frq_sel,
  input  logic       i_logic_frq_sel_vld,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx,
  output logic       o_tx_done
);

  tx_state_t   state, state_next;
  logic [3:0]  sel;
  logic [15:0] lp_table [16];
  logic [15:0] lp_sel;
  logic [7:0]  shift, shift_next;
  logic [2:0]  idx, idx_next;
  logic        tx_q, tx_next;
  logic        accept;
  logic        tick;

  // Bit period for every select code is a constant; the live select just
  // picks one entry, so no divider is built.
  for (genvar g = 0; g < 16; g++) begin : g_lp
    assign lp_table[g] = bit_period(4'(g), BAUD, MIN_BIT);
  end

  assign lp_sel     = lp_table[sel];
  assign o_tx_ready = (state == ST_IDLE);
  assign accept     = i_tx_valid && o_tx_ready;
  assign o_tx       = tx_q;
  assign o_tx_done  = (state == ST_STOP) && tick;

  uart_bit_timer u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load   (accept),
    .period (lp_sel),
    .run    (state != ST_IDLE),
    .tick   (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity;

  // Even parity of the accepted byte, held for the frame.
  always_ff @(posedge i_clk) begin
    if (accept) parity <= ^i_tx_data;
  end
`endif

  // Control state: FSM, bit index, registered line and frequency select.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      idx   <= 3'd0;
      tx_q  <= 1'b1;
      sel   <= 4'hF;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      tx_q  <= tx_next;
      if (i_logic_frq_sel_vld) sel <= i_logic_frq_sel;
    end
  end

  // Shift register for the outgoing byte; pure data, no reset needed.
  always_ff @(posedge i_clk) begin
    shift <= shift_next;
  end

  // Next-state logic; the line value is computed for the coming state so
  // o_tx comes straight from a flop.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    shift_next = shift;
    tx_next    = tx_q;
    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next = ST_START;
          shift_next = i_tx_data;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_next = ST_DATA;
          idx_next   = 3'd0;
          tx_next    = shift[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
            tx_next    = parity;
`else
            state_next = ST_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            idx_next = idx + 3'd1;
            tx_next  = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_next = ST_IDLE;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
